// File: rtl/product_acc_pkg.sv
// Shared constants for the product accumulator: default widths, term-count width, legality checks.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package product_acc_pkg;

  // Width of term counters and of out_terms; covers MAX_TERMS up to 15.
  localparam int CNT_W            = 4;

  localparam int DEF_P_W          = 32;
  localparam int DEF_MULT_LATENCY = 3;
  localparam int DEF_ACC_W        = 40;
  localparam int DEF_SHIFT        = 8;
  localparam int DEF_OUT_W        = 8;
  localparam int DEF_MAX_TERMS    = 9;

  localparam int MIN_TERMS_LIMIT  = 2;
  localparam int MAX_TERMS_LIMIT  = 15;

  function automatic bit terms_legal(input int n);
    return (n >= MIN_TERMS_LIMIT) && (n <= MAX_TERMS_LIMIT);
  endfunction

  function automatic bit shift_legal(input int s, input int acc_w);
    return (s >= 0) && (s < acc_w);
  endfunction

  localparam bit DEF_TERMS_OK = terms_legal(DEF_MAX_TERMS);
  localparam bit DEF_SHIFT_OK = shift_legal(DEF_SHIFT, DEF_ACC_W);

endpackage

// File: rtl/valid_delay_line.sv
// ce-gated DEPTH x WIDTH shift register with async active-low clear.
// Latency: DEPTH ce-enabled cycles from i_d to o_q.
// Backpressure: none; holds all stages while ce=0.
// Ports: clk, rst_n (async clear), ce (advance), i_d (stage-0 input), o_q (last stage).
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (ce) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// Sums a group of multiplier products into one scaled, saturated feature value.
// Latency: input cycle T -> out_valid in cycle T+MULT_LATENCY+1 (ce=1 throughout).
// Backpressure: none; every out_valid pulse must be consumed.
// Ports: clk, rst_n (async active-low), ce, in_valid, in_last, p (product),
//        out_valid (1-clk pulse), out_data, out_terms, err_overrun (sticky).
// Option: define PRODUCT_ACC_ROUND_EN for round-half-up before the shift.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int P_W          = DEF_P_W,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int ACC_W        = DEF_ACC_W,
  parameter int SHIFT        = DEF_SHIFT,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int MAX_TERMS    = DEF_MAX_TERMS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [P_W-1:0]   p,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_terms,
  output logic             err_overrun
);

  localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(MAX_TERMS);

  // {valid,last} travel alongside the multiplier so they line up with p.
  logic [1:0] w_dl_in;
  logic [1:0] w_dl_out;
  logic       w_al_vld;
  logic       w_al_last;

  assign w_dl_in = {in_valid, in_valid & in_last};

  valid_delay_line #(
    .DEPTH(MULT_LATENCY),
    .WIDTH(2)
  ) u_valid_delay_line (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .i_d  (w_dl_in),
    .o_q  (w_dl_out)
  );

  assign w_al_vld  = w_dl_out[1];
  assign w_al_last = w_dl_out[0];

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_term_cnt;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_terms;
  logic             r_err;

  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_take;
  logic             w_full;
  logic             w_close;
  logic [ACC_W-1:0] w_rnd;
  logic [ACC_W-1:0] w_res;
  logic [OUT_W-1:0] w_out;

  // First term of a group starts from zero regardless of stale acc contents.
  assign w_base     = (r_term_cnt == '0) ? '0 : r_acc;
  assign w_sum      = {1'b0, w_base} + {{(ACC_W+1-P_W){1'b0}}, p};
  // A carry pins the sum at all ones; further carries keep it there.
  assign w_acc_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  assign w_cnt_next = r_term_cnt + CNT_W'(1);

  assign w_take  = ce & w_al_vld;
  assign w_full  = (w_cnt_next == LP_MAX_CNT);
  assign w_close = w_take & (w_al_last | w_full);

`ifdef PRODUCT_ACC_ROUND_EN
  localparam int             LP_HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] LP_ONE      = {{ACC_W{1'b0}}, 1'b1};
  localparam logic [ACC_W:0] LP_HALF     = (SHIFT > 0) ? (LP_ONE << LP_HALF_POS) : '0;

  logic [ACC_W:0] w_rnd_sum;
  assign w_rnd_sum = {1'b0, w_acc_next} + LP_HALF;
  assign w_rnd     = w_rnd_sum[ACC_W] ? '1 : w_rnd_sum[ACC_W-1:0];
`else
  assign w_rnd = w_acc_next;
`endif

  assign w_res = w_rnd >> SHIFT;
  assign w_out = (|w_res[ACC_W-1:OUT_W]) ? '1 : w_res[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_term_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_terms <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_close;
      if (w_take) begin
        if (w_close) begin
          r_acc       <= '0;
          r_term_cnt  <= '0;
          r_out_data  <= w_out;
          r_out_terms <= w_cnt_next;
          // Hitting the term limit without last is an implicit close.
          if (!w_al_last) r_err <= 1'b1;
        end else begin
          r_acc      <= w_acc_next;
          r_term_cnt <= w_cnt_next;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_terms   = r_out_terms;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int ML   = 3;
  localparam int MAXT = 9;
  localparam int SH   = 8;
  localparam logic [63:0] ACC_MAX = (64'd1 << 40) - 64'd1;
`ifdef PRODUCT_ACC_ROUND_EN
  localparam logic [7:0] T1_EXP = 8'd2;
`else
  localparam logic [7:0] T1_EXP = 8'd1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic        in_last;
  logic [31:0] p;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_terms;
  logic        err_overrun;

  product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .p          (p),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_terms  (out_terms),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ce_idx   = 0;
  int n_step   = 0;
  int n_pulse  = 0;
  int pulse_step = 0;
  int base_pulse;
  int first_step;

  // Multiplier stand-in: products emerge ML ce-cycles after their operands.
  logic [31:0] pipe [ML];

  // Reference model: running group sum and expected results keyed by the
  // ce-cycle index in which the closing term reaches the accumulator.
  logic [63:0] grp_sum;
  int          grp_n;
  logic [7:0]  ev_data  [int];
  logic [3:0]  ev_terms [int];
  bit          ev_ovr   [int];
  logic [7:0]  exp_data;
  logic [3:0]  exp_terms;
  logic        exp_err;

  logic [7:0] seen_data, prev_data;
  logic [3:0] seen_terms, prev_terms;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_out(input logic [63:0] s);
    logic [63:0] v;
    v = (s > ACC_MAX) ? ACC_MAX : s;
`ifdef PRODUCT_ACC_ROUND_EN
    v = (v + 64'd128 > ACC_MAX) ? ACC_MAX : v + 64'd128;
`endif
    v = v >> SH;
    return (v > 64'd255) ? 8'hFF : v[7:0];
  endfunction

  task automatic model_push(input logic [31:0] prod, input logic last, input int k);
    grp_sum = grp_sum + {32'd0, prod};
    grp_n++;
    if (last || grp_n == MAXT) begin
      ev_data[k+ML]  = ref_out(grp_sum);
      ev_terms[k+ML] = grp_n[3:0];
      ev_ovr[k+ML]   = !last;
      grp_sum = 0;
      grp_n   = 0;
    end
  endtask

  task automatic model_clear();
    grp_sum = 0;
    grp_n   = 0;
    ev_data.delete();
    ev_terms.delete();
    ev_ovr.delete();
    exp_data  = 0;
    exp_terms = 0;
    exp_err   = 0;
  endtask

  task automatic check_outputs(input int j);
    bit e;
    e = (j >= 0) && ev_data.exists(j);
    chk("out_valid", {63'd0, out_valid}, {63'd0, e});
    if (out_valid === 1'b1) begin
      n_pulse++;
      pulse_step = n_step;
      prev_data  = seen_data;
      prev_terms = seen_terms;
      seen_data  = out_data;
      seen_terms = out_terms;
    end
    if (e) begin
      exp_data  = ev_data[j];
      exp_terms = ev_terms[j];
      if (ev_ovr[j]) exp_err = 1'b1;
      ev_data.delete(j);
      ev_terms.delete(j);
      ev_ovr.delete(j);
    end
    chk("out_data", {56'd0, out_data}, {56'd0, exp_data});
    chk("out_terms", {60'd0, out_terms}, {60'd0, exp_terms});
    chk("err_overrun", {63'd0, err_overrun}, {63'd0, exp_err});
  endtask

  task automatic step(input logic v, input logic l, input logic c, input logic [31:0] prod);
    int j;
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    ce       = c;
    p        = pipe[ML-1];
    n_step++;
    j = -1;
    if (c) begin
      ce_idx++;
      j = ce_idx;
      if (v) model_push(prod, l, ce_idx);
    end
    @(posedge clk);
    if (c) begin
      for (int i = ML - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = prod;
    end
    #1;
    check_outputs(j);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, $urandom);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n    = 1'b0;
    ce       = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_clear();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {56'd0, out_data}, 64'd0);
      chk("rst_out_terms", {60'd0, out_terms}, 64'd0);
      chk("rst_err", {63'd0, err_overrun}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; in_last = 1'b0; p = '0;
    for (int i = 0; i < ML; i++) pipe[i] = '0;
    seen_data = 0; prev_data = 0; seen_terms = 0; prev_terms = 0;
    model_clear();
    do_reset(2);

    // Basic group of three, truncation/rounding of the scaled sum.
    base_pulse = n_pulse;
    step(1, 0, 1, 32'h100);
    step(1, 0, 1, 32'h80);
    step(1, 1, 1, 32'h0);
    idle(6);
    chk("t1_pulses", n_pulse - base_pulse, 1);
    chk("t1_data", {56'd0, seen_data}, {56'd0, T1_EXP});
    chk("t1_terms", {60'd0, seen_terms}, 64'd3);

    // Output saturation on a large sum.
    base_pulse = n_pulse;
    for (int i = 0; i < 3; i++) step(1, (i == 2), 1, 32'hFFFE0001);
    idle(6);
    chk("t2_pulses", n_pulse - base_pulse, 1);
    chk("t2_data", {56'd0, seen_data}, 64'hFF);
    chk("t2_err", {63'd0, err_overrun}, 64'd0);

    // Ten terms with no last: implicit close at nine, tenth opens a new group.
    base_pulse = n_pulse;
    for (int i = 0; i < 10; i++) step(1, 0, 1, 32'h10);
    step(1, 1, 1, 32'h10);
    idle(6);
    chk("t3_pulses", n_pulse - base_pulse, 2);
    chk("t3_first_terms", {60'd0, prev_terms}, 64'd9);
    chk("t3_second_terms", {60'd0, seen_terms}, 64'd2);
    chk("t3_err", {63'd0, err_overrun}, 64'd1);

    // Back-to-back groups with no bubble.
    base_pulse = n_pulse;
    step(1, 0, 1, 32'h200);
    step(1, 1, 1, 32'h200);
    step(1, 1, 1, 32'h300);
    idle(6);
    chk("t4_pulses", n_pulse - base_pulse, 2);
    chk("t4_first_data", {56'd0, prev_data}, 64'h4);
    chk("t4_first_terms", {60'd0, prev_terms}, 64'd2);
    chk("t4_second_data", {56'd0, seen_data}, 64'h3);
    chk("t4_second_terms", {60'd0, seen_terms}, 64'd1);

    // ce stall of five cycles mid-group; inputs during the stall are ignored.
    base_pulse = n_pulse;
    first_step = n_step + 1;
    step(1, 0, 1, 32'h100);
    step(1, 0, 1, 32'h100);
    for (int i = 0; i < 5; i++) step(1, 1, 0, $urandom);
    step(1, 1, 1, 32'h100);
    idle(8);
    chk("t5_pulses", n_pulse - base_pulse, 1);
    chk("t5_data", {56'd0, seen_data}, 64'h3);
    chk("t5_terms", {60'd0, seen_terms}, 64'd3);
    chk("t5_latency", pulse_step - first_step, 10);

    // Reset mid-group discards the partial group.
    step(1, 0, 1, 32'h100);
    step(1, 0, 1, 32'h100);
    do_reset(2);
    base_pulse = n_pulse;
    step(1, 1, 1, 32'h500);
    idle(8);
    chk("t6_pulses", n_pulse - base_pulse, 1);
    chk("t6_data", {56'd0, seen_data}, 64'h5);
    chk("t6_terms", {60'd0, seen_terms}, 64'd1);
    chk("t6_err", {63'd0, err_overrun}, 64'd0);

    // Random traffic: stalls, gaps, random group lengths and magnitudes.
    for (int i = 0; i < 400; i++) begin
      logic        rv, rl, rc;
      logic [31:0] rp;
      rc = ($urandom_range(0, 9) != 0);
      rv = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 4) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 'h3FF);
      step(rv, rl, rc, rp);
    end
    idle(8);
    chk("leftover_events", ev_data.num(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
